// File: rtl/alu_decoder_rv32i.sv
// RV32I ALU operation decoder: instruction class + one-hot funct3 + funct7 flags -> registered ALU_op/illegal.
// Build option: define ALU_DEC_M_EXT_EN to decode the M-extension ops (MUL/DIV/REM) under funct7 == 0x01.
module alu_decoder_rv32i (
  input  logic       clk,
  input  logic       rst,
  input  logic       R,
  input  logic       I,
  input  logic       U,
  input  logic       VR,
  input  logic       abs,
  input  logic [7:0] decoded_f3,
  input  logic       f7_eq_0x0,
  input  logic       f7_eq_0x1,
  input  logic       f7_eq_0x20,
  output logic [3:0] ALU_op,
  output logic       illegal
);

  localparam int unsigned OP_W = 4;
  localparam int unsigned F3_W = 8;
  localparam int unsigned F3_IDX_W = 3;

  localparam logic [OP_W-1:0] OP_ADD    = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB    = 4'h1;
  localparam logic [OP_W-1:0] OP_SLL    = 4'h2;
  localparam logic [OP_W-1:0] OP_SLT    = 4'h3;
  localparam logic [OP_W-1:0] OP_SLTU   = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR    = 4'h5;
  localparam logic [OP_W-1:0] OP_SRL    = 4'h6;
  localparam logic [OP_W-1:0] OP_SRA    = 4'h7;
  localparam logic [OP_W-1:0] OP_OR     = 4'h8;
  localparam logic [OP_W-1:0] OP_AND    = 4'h9;
`ifdef ALU_DEC_M_EXT_EN
  localparam logic [OP_W-1:0] OP_MUL    = 4'hA;
  localparam logic [OP_W-1:0] OP_DIV    = 4'hB;
  localparam logic [OP_W-1:0] OP_REM    = 4'hC;
`endif
  localparam logic [OP_W-1:0] OP_PASS_B = 4'hD;
  localparam logic [OP_W-1:0] OP_ABS    = 4'hE;

  logic [F3_IDX_W-1:0] f3_idx_c;
  logic                f3_onehot_c;
  logic                f7_multi_c;
  logic [OP_W-1:0]     op_c;
  logic                illegal_c;

  // Binary funct3 index; only meaningful when decoded_f3 is one-hot
  always_comb begin
    f3_idx_c = '0;
    for (int n = 0; n < int'(F3_W); n++) begin
      if (decoded_f3[n]) f3_idx_c = F3_IDX_W'(n);
    end
  end

  assign f3_onehot_c = $onehot(decoded_f3);
  assign f7_multi_c  = (f7_eq_0x0 & f7_eq_0x1) | (f7_eq_0x0 & f7_eq_0x20) | (f7_eq_0x1 & f7_eq_0x20);

  // Class-priority decode: abs > U > R/VR > I > address generation
  always_comb begin
    op_c      = OP_ADD;
    illegal_c = 1'b0;
    if (abs) begin
      op_c = OP_ABS;
    end else if (U) begin
      op_c = OP_PASS_B;
    end else if (R || VR) begin
      if (!f3_onehot_c || f7_multi_c) begin
        illegal_c = 1'b1;
      end else if (f7_eq_0x0) begin
        case (f3_idx_c)
          3'd0:    op_c = OP_ADD;
          3'd1:    op_c = OP_SLL;
          3'd2:    op_c = OP_SLT;
          3'd3:    op_c = OP_SLTU;
          3'd4:    op_c = OP_XOR;
          3'd5:    op_c = OP_SRL;
          3'd6:    op_c = OP_OR;
          default: op_c = OP_AND;
        endcase
      end else if (f7_eq_0x20) begin
        case (f3_idx_c)
          3'd0:    op_c = OP_SUB;
          3'd5:    op_c = OP_SRA;
          default: illegal_c = 1'b1;
        endcase
      end else if (f7_eq_0x1) begin
`ifdef ALU_DEC_M_EXT_EN
        case (f3_idx_c)
          3'd0:    op_c = OP_MUL;
          3'd4:    op_c = OP_DIV;
          3'd6:    op_c = OP_REM;
          default: illegal_c = 1'b1;
        endcase
`else
        illegal_c = 1'b1;
`endif
      end else begin
        illegal_c = 1'b1;
      end
    end else if (I) begin
      if (!f3_onehot_c) begin
        illegal_c = 1'b1;
      end else begin
        // Only the shift encodings look at funct7
        case (f3_idx_c)
          3'd0: op_c = OP_ADD;
          3'd1: begin
            if (f7_eq_0x0 && !f7_multi_c) op_c = OP_SLL;
            else                           illegal_c = 1'b1;
          end
          3'd2: op_c = OP_SLT;
          3'd3: op_c = OP_SLTU;
          3'd4: op_c = OP_XOR;
          3'd5: begin
            if (f7_multi_c)      illegal_c = 1'b1;
            else if (f7_eq_0x0)  op_c = OP_SRL;
            else if (f7_eq_0x20) op_c = OP_SRA;
            else                 illegal_c = 1'b1;
          end
          3'd6:    op_c = OP_OR;
          default: op_c = OP_AND;
        endcase
      end
    end
    if (illegal_c) op_c = OP_ADD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_op  <= OP_ADD;
      illegal <= 1'b0;
    end else begin
      ALU_op  <= op_c;
      illegal <= illegal_c;
    end
  end

endmodule

// File: tb/tb_alu_decoder_rv32i.sv
// Scoreboard bench for alu_decoder_rv32i: directed vectors push expectations, a monitor pops and compares each cycle.
module tb_alu_decoder_rv32i;

  typedef struct {
    logic [3:0] op;
    logic       ill;
    string      name;
  } exp_t;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_I    = 5'b00001;
  localparam logic [4:0] C_R    = 5'b00010;
  localparam logic [4:0] C_VR   = 5'b00100;
  localparam logic [4:0] C_U    = 5'b01000;
  localparam logic [4:0] C_ABS  = 5'b10000;
  localparam logic [2:0] F7_0   = 3'b001;
  localparam logic [2:0] F7_1   = 3'b010;
  localparam logic [2:0] F7_20  = 3'b100;

`ifdef ALU_DEC_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       R = 1'b0, I = 1'b0, U = 1'b0, VR = 1'b0, abs = 1'b0;
  logic [7:0] decoded_f3 = 8'h00;
  logic       f7_eq_0x0 = 1'b0, f7_eq_0x1 = 1'b0, f7_eq_0x20 = 1'b0;
  logic [3:0] ALU_op;
  logic       illegal;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_decoder_rv32i dut (
    .clk(clk), .rst(rst), .R(R), .I(I), .U(U), .VR(VR), .abs(abs),
    .decoded_f3(decoded_f3), .f7_eq_0x0(f7_eq_0x0), .f7_eq_0x1(f7_eq_0x1),
    .f7_eq_0x20(f7_eq_0x20), .ALU_op(ALU_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] op, input logic ill);
    n_checks++;
    if (ALU_op === op && illegal === ill) n_pass++;
    else $display("FAIL %s: got op=%h illegal=%b, expected op=%h illegal=%b", name, ALU_op, illegal, op, ill);
  endtask

  task automatic drive(input logic [4:0] cls, input logic [7:0] f3, input logic [2:0] f7);
    {abs, U, VR, R, I} = cls;
    decoded_f3 = f3;
    {f7_eq_0x20, f7_eq_0x1, f7_eq_0x0} = f7;
  endtask

  // Drive at the falling edge; the following rising edge registers it
  task automatic apply(input string name, input logic [4:0] cls, input logic [7:0] f3,
                       input logic [2:0] f7, input logic [3:0] op, input logic ill);
    exp_t e;
    drive(cls, f3, f7);
    e.op = op; e.ill = ill; e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: one registered result per edge while expectations are pending
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, e.op, e.ill);
      end
    end
  end

  // Async reset mid-stream: outputs clear before the edge, held, then next edge decodes current inputs
  task automatic reset_pulse(input string name, input logic [4:0] cls, input logic [7:0] f3,
                             input logic [2:0] f7, input logic [3:0] op, input logic ill);
    drive(cls, f3, f7);
    #2;
    rst = 1'b1;
    #1;
    check({name, "_async"}, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    check({name, "_hold"}, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply({name, "_release"}, cls, f3, f7, op, ill);
  endtask

  initial begin
    #1;
    check("reset_state", 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    apply("noclass_add",  C_NONE, 8'h01, 3'b000, 4'h0, 1'b0);
    apply("r_sub",        C_R,    8'h01, F7_20,  4'h1, 1'b0);
    apply("r_add",        C_R,    8'h01, F7_0,   4'h0, 1'b0);
    apply("r_nof7",       C_R,    8'h01, 3'b000, 4'h0, 1'b1);
    apply("r_mul",        C_R,    8'h01, F7_1,   M_EN ? 4'hA : 4'h0, !M_EN);
    apply("r_div",        C_R,    8'h10, F7_1,   M_EN ? 4'hB : 4'h0, !M_EN);
    apply("r_rem",        C_R,    8'h40, F7_1,   M_EN ? 4'hC : 4'h0, !M_EN);
    apply("r_m_bad_f3",   C_R,    8'h02, F7_1,   4'h0, 1'b1);
    apply("vr_rem",       C_VR,   8'h40, F7_1,   M_EN ? 4'hC : 4'h0, !M_EN);
    apply("i_sra",        C_I,    8'h20, F7_20,  4'h7, 1'b0);
    apply("i_srl",        C_I,    8'h20, F7_0,   4'h6, 1'b0);
    apply("i_sr_nof7",    C_I,    8'h20, 3'b000, 4'h0, 1'b1);
    apply("abs_over_r",   C_ABS | C_R, 8'h01, F7_20, 4'hE, 1'b0);
    apply("i_f3_multi",   C_I,    8'h03, 3'b000, 4'h0, 1'b1);
    apply("u_pass_b",     C_U,    8'h03, 3'b000, 4'hD, 1'b0);
    apply("u_f3_zero",    C_U,    8'h00, F7_1,   4'hD, 1'b0);
    apply("r_and",        C_R,    8'h80, F7_0,   4'h9, 1'b0);
    apply("r_sltu",       C_R,    8'h08, F7_0,   4'h4, 1'b0);
    apply("r_srl",        C_R,    8'h20, F7_0,   4'h6, 1'b0);
    apply("r_sll",        C_R,    8'h02, F7_0,   4'h2, 1'b0);
    apply("r_or",         C_R,    8'h40, F7_0,   4'h8, 1'b0);
    apply("vr_sra",       C_VR,   8'h20, F7_20,  4'h7, 1'b0);
    apply("vr_f720_bad",  C_VR,   8'h04, F7_20,  4'h0, 1'b1);
    apply("i_xor_f7ign",  C_I,    8'h10, F7_20,  4'h5, 1'b0);
    apply("i_slt",        C_I,    8'h04, 3'b000, 4'h3, 1'b0);
    apply("i_and",        C_I,    8'h80, F7_1,   4'h9, 1'b0);
    apply("i_sll_f720",   C_I,    8'h02, F7_20,  4'h0, 1'b1);
    apply("i_sll",        C_I,    8'h02, F7_0,   4'h2, 1'b0);
    apply("i_sr_multif7", C_I,    8'h20, F7_0 | F7_20, 4'h0, 1'b1);
    apply("r_multif7",    C_R,    8'h01, F7_0 | F7_20, 4'h0, 1'b1);
    apply("r_f3_zero",    C_R,    8'h00, F7_0,   4'h0, 1'b1);
    apply("r_over_i",     C_R | C_I, 8'h01, F7_20, 4'h1, 1'b0);
    apply("u_over_r",     C_U | C_R, 8'h01, F7_20, 4'hD, 1'b0);
    apply("i_add_nof7",   C_I,    8'h01, 3'b000, 4'h0, 1'b0);

    apply("pre_rst_sub",  C_R,    8'h01, F7_20,  4'h1, 1'b0);
    reset_pulse("rst1",   C_R,    8'h80, F7_0,   4'h9, 1'b0);
    apply("pre_rst_ill",  C_R,    8'h01, 3'b000, 4'h0, 1'b1);
    reset_pulse("rst2",   C_I,    8'h20, F7_20,  4'h7, 1'b0);

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations still pending, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_decoder_rv32i.md
ALU_DECODER_RV32I -- requirements
Module: alu_decoder_rv32i

Interface
REQ-001 No parameters; the only build-time option is the macro in Configuration.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 R  input  1  R-type integer instruction class.
REQ-005 I  input  1  I-type ALU instruction class (OP-IMM).
REQ-006 U  input  1  U-type instruction class.
REQ-007 VR  input  1  vector register-register class; decoded identically to R.
REQ-008 abs  input  1  custom absolute-value instruction.
REQ-009 decoded_f3  input  8  one-hot funct3; bit n set means funct3 == n.
REQ-010 f7_eq_0x0 / f7_eq_0x1 / f7_eq_0x20  input  1 each  funct7 equals 0x00 / 0x01 / 0x20.
REQ-011 ALU_op  output  4  registered ALU operation code.
REQ-012 illegal  output  1  registered flag: current combination is not a legal ALU operation.

Function
REQ-013 ALU_op encoding: 0x0 ADD, 0x1 SUB, 0x2 SLL, 0x3 SLT, 0x4 SLTU, 0x5 XOR, 0x6 SRL, 0x7 SRA, 0x8 OR, 0x9 AND, 0xA MUL, 0xB DIV, 0xC REM, 0xD PASS_B, 0xE ABS, 0xF reserved (never produced).
REQ-014 Class priority: abs > U > (R or VR) > I > none.
REQ-015 abs=1 -> ABS, illegal=0, regardless of all other inputs.
REQ-016 U=1 (abs=0) -> PASS_B, illegal=0; funct3/funct7 ignored.
REQ-017 R or VR with f7_eq_0x0: funct3 0..7 -> ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
REQ-018 R or VR with f7_eq_0x20: funct3 0 -> SUB, funct3 5 -> SRA; any other funct3 is illegal.
REQ-019 R or VR with f7_eq_0x1: funct3 0 -> MUL, 4 -> DIV, 6 -> REM; any other funct3 is illegal.
REQ-020 R or VR with none of the three funct7 flags set is illegal.
REQ-021 I: funct3 0 ADD, 2 SLT, 3 SLTU, 4 XOR, 6 OR, 7 AND; funct7 flags ignored for these.
REQ-022 I funct3 1: SLL only if f7_eq_0x0, else illegal; I funct3 5: SRL if f7_eq_0x0, SRA if f7_eq_0x20, else illegal.
REQ-023 No class flag set -> ADD, illegal=0 (address generation for load/store/branch/jump).
REQ-024 decoded_f3 not exactly one-hot (zero or multiple bits), for R/VR/I classes -> illegal.
REQ-025 More than one funct7 flag set, for R/VR/I shift cases -> illegal.
REQ-026 Any illegal combination drives ALU_op = ADD (0x0) together with illegal=1.
REQ-027 Latency exactly one cycle: outputs reflect the inputs sampled at the previous rising clk edge; outputs update on every edge, with no enable and no handshake.

Reset
REQ-028 rst=1 asynchronously forces ALU_op=0x0 and illegal=0 immediately, without waiting for a clk edge.
REQ-029 While rst is held, outputs stay at reset values; the first rising edge after deassertion registers the current inputs.
REQ-030 Reset asserted mid-stream discards the pending decode; no stale value appears after release.

Configuration
REQ-031 Macro ALU_DEC_M_EXT_EN defined: f7_eq_0x1 decoding per REQ-019 is present.
REQ-032 Macro undefined: every R/VR combination with f7_eq_0x1 is illegal (ALU_op=0x0, illegal=1); all other behaviour is unchanged.

Verification
REQ-033 All inputs 0, decoded_f3=0x01, one edge -> ALU_op=0x0, illegal=0.
REQ-034 R=1, decoded_f3=0x01, f7_eq_0x20=1 -> SUB 0x1; same inputs with f7_eq_0x0=1 -> ADD 0x0; R=1 with decoded_f3=0x01 and no funct7 flag -> 0x0, illegal=1.
REQ-035 R=1, f7_eq_0x1=1, decoded_f3 = 0x01 / 0x10 / 0x40 -> 0xA / 0xB / 0xC with the macro defined; -> 0x0 with illegal=1 when the macro is undefined.
REQ-036 I=1, decoded_f3=0x20: f7_eq_0x20 -> 0x7; f7_eq_0x0 -> 0x6; neither flag -> illegal=1; abs=1 together with R=1 -> 0xE.
REQ-037 decoded_f3=0x03 with I=1 -> illegal=1; U=1 with any funct3 -> 0xD.
REQ-038 Drive a legal op, then assert rst between clk edges -> outputs reach 0x0/0 before the next edge; release -> the next edge shows the decode of the current inputs.
